diods_echo_receiver: RTL and testbench
======================================

# diods_echo_receiver

Receive-side counterpart of the diode pulse generator: after each fire request it watches the asynchronous photodiode echo line, qualifies it, measures the echo pulse width in 200 MHz cycles and hands one result word per shot to the STM/SPI side over a valid/ready handshake. It sits between the optical front-end input pin and the readout logic, in the same 200 MHz domain as the fire-request logic.

## Interface
- FILTER, 4, consecutive identical synchronized samples required to change the filtered level (≥1)
- W, 16, width of width/window counters and result_width_o
- MIN_CYCLES, 16'd8, widths below this are flagged short
- MAX_CYCLES, 16'd4000, high-time limit; must be < 2^W
- WINDOW, 16'd2000, cycles allowed from arm to echo rising edge; must be < 2^W
- clk_200MHz_i  in  1  single system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle arm pulse, issued together with the diode fire request
- diode_echo_i  in  1  raw echo from photodiode comparator, asynchronous
- result_ready_i  in  1  consumer accepts result when high with result_valid_o
- result_valid_o  out  1  result register holds an unconsumed result
- result_width_o  out  W  measured high time in clk cycles
- result_err_o  out  2  00 ok, 01 short, 10 too long, 11 no echo
- busy_o  out  1  FSM not in IDLE
- overrun_cnt_o  out  8  saturating count of results dropped because the output was full

## Operation
- Input path: 2-flop synchronizer → s; filter keeps level f and a run counter; f flips after s differs from f for FILTER consecutive edges; counter clears whenever s equals f. f_prev is f delayed one cycle.
- FSM states: IDLE, ARMED, HIGH, WAIT_LOW.
- IDLE: start_i → ARMED, window counter cleared to 0. Echo activity ignored. start_i in any other state is ignored.
- ARMED: window counter increments each cycle. Rising edge (f=1, f_prev=0) → HIGH, width counter loaded with 1. If no edge and window counter == WINDOW-1 → write result {width 0, err 11}, → IDLE. A level already high at arm does not count; a fresh low→high edge is required.
- HIGH: each edge with f=1 increments width counter. f=0 → write result {width, err = 01 if width < MIN_CYCLES else 00}, → IDLE. If width == MAX_CYCLES and f=1 → write result {MAX_CYCLES, 10}, → WAIT_LOW.
- WAIT_LOW: stay until f=0, then → IDLE (no further result).
- Result write: if result_valid_o=0, or result_ready_i=1 at the same edge, load width/err and set valid. Otherwise drop the new result and increment overrun_cnt_o, saturating at 255.
- Handshake: the transfer occurs on an edge with valid & ready. Valid clears unless a new result loads on that same edge. Width/err hold stable while valid is high.
- Width arithmetic: unsigned W-bit; the counter never exceeds MAX_CYCLES, so no wrap.

## Timing
- Reset: all outputs 0, FSM IDLE, synchronizer, f, f_prev and counters 0. Effective immediately on reset_n low, mid-operation included; a pending result is discarded.
- Filter latency: f changes FILTER+2 edges after the first edge sampling the new input level.
- For a clean input high for H cycles, f is high exactly H cycles and result_width_o = H.
- result_valid_o rises FILTER+3 edges after the first edge sampling the input low.
- No-echo result valid WINDOW edges after the edge sampling start_i, plus one.
- Too-long result valid one edge after the width counter reaches MAX_CYCLES.
- busy_o = (state != IDLE), registered-state based, so high from the edge after start_i.
- Input pulses shorter than FILTER cycles are invisible; a glitch of FILTER-1 cycles inside a high pulse does not split it.
- Back-to-back shots: start_i is accepted on the first cycle after returning to IDLE.

## Test plan
- Clean echo: start_i, echo high 100 cycles at arm+50 → one result {100, 00}, valid at input-fall+FILTER+3, ready held high → valid lasts 1 cycle.
- Short and glitch: echo high 3 cycles (FILTER=4) → no edge, {0, 11} after WINDOW; echo high 6 cycles → {6, 01}; a 3-cycle low gap inside 200-cycle high → {200, 00}.
- Too long: echo stuck high → {4000, 10}; busy_o stays high until echo low is filtered, then start_i accepted again.
- Backpressure: ready=0, two shots complete → first result held unchanged, overrun_cnt_o=1; ready on load edge → new result replaces old, count unchanged; 300 drops → count 255.
- Arm with echo already high: start_i while echo high, echo falls then rises for 20 cycles → {20, 00}; start_i during HIGH ignored.
- Reset mid-HIGH: reset_n low for 2 cycles during pulse → all outputs 0 asynchronously, FSM IDLE, no result after release until next start_i.

Source files
------------

// File: rtl/diods_echo_receiver.sv
// rtl/diods_echo_receiver.sv - photodiode echo qualifier and pulse-width meter
// One result word per shot (width, error code) handed off over valid/ready.
module diods_echo_receiver #(
  parameter int unsigned  FILTER     = 4,
  parameter int unsigned  W          = 16,
  parameter logic [W-1:0] MIN_CYCLES = 16'd8,
  parameter logic [W-1:0] MAX_CYCLES = 16'd4000,
  parameter logic [W-1:0] WINDOW     = 16'd2000
) (
  input  logic         clk_200MHz_i,
  input  logic         reset_n,
  input  logic         start_i,
  input  logic         diode_echo_i,
  input  logic         result_ready_i,
  output logic         result_valid_o,
  output logic [W-1:0] result_width_o,
  output logic [1:0]   result_err_o,
  output logic         busy_o,
  output logic [7:0]   overrun_cnt_o
);

  localparam int unsigned  FW       = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [FW-1:0] RUN_LAST = FW'(FILTER - 1);
  localparam logic [W-1:0]  WIN_LAST = WINDOW - 1'b1;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;
  localparam logic [1:0] ERR_NONE  = 2'b11;

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, WAIT_LOW} state_t;

  logic [1:0]    sync_q;
  logic          s;
  logic          f_q;
  logic          f_prev_q;
  logic [FW-1:0] run_q;

  state_t        state_q, state_d;
  logic [W-1:0]  win_q, win_d;
  logic [W-1:0]  width_q, width_d;
  logic          wr_req;
  logic [W-1:0]  wr_width;
  logic [1:0]    wr_err;

  assign s = sync_q[1];

  // Filtered level only flips after FILTER consecutive disagreeing samples.
  always_ff @(posedge clk_200MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 2'b00;
      f_q      <= 1'b0;
      f_prev_q <= 1'b0;
      run_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], diode_echo_i};
      f_prev_q <= f_q;
      if (s == f_q) begin
        run_q <= '0;
      end else if (run_q == RUN_LAST) begin
        f_q   <= s;
        run_q <= '0;
      end else begin
        run_q <= run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_200MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      width_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      width_q <= width_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    width_d  = width_q;
    wr_req   = 1'b0;
    wr_width = '0;
    wr_err   = ERR_OK;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ARMED;
          win_d   = '0;
        end
      end
      ARMED: begin
        // A level already high at arm has f_prev=1, so only a fresh edge counts.
        if (f_q && !f_prev_q) begin
          state_d = HIGH;
          width_d = W'(1);
        end else if (win_q == WIN_LAST) begin
          wr_req  = 1'b1;
          wr_err  = ERR_NONE;
          state_d = IDLE;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      HIGH: begin
        if (!f_q) begin
          wr_req   = 1'b1;
          wr_width = width_q;
          wr_err   = (width_q < MIN_CYCLES) ? ERR_SHORT : ERR_OK;
          state_d  = IDLE;
        end else if (width_q == MAX_CYCLES) begin
          wr_req   = 1'b1;
          wr_width = MAX_CYCLES;
          wr_err   = ERR_LONG;
          state_d  = WAIT_LOW;
        end else begin
          width_d = width_q + 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!f_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A consumer taking the old word on the load edge frees the slot for the new one.
  always_ff @(posedge clk_200MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      result_valid_o <= 1'b0;
      result_width_o <= '0;
      result_err_o   <= 2'b00;
      overrun_cnt_o  <= 8'd0;
    end else if (wr_req) begin
      if (!result_valid_o || result_ready_i) begin
        result_valid_o <= 1'b1;
        result_width_o <= wr_width;
        result_err_o   <= wr_err;
      end else if (overrun_cnt_o != 8'hFF) begin
        overrun_cnt_o <= overrun_cnt_o + 1'b1;
      end
    end else if (result_valid_o && result_ready_i) begin
      result_valid_o <= 1'b0;
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_diods_echo_receiver.sv
// tb/tb_diods_echo_receiver.sv - self-checking bench for diods_echo_receiver
`timescale 1ns/1ps
module tb_diods_echo_receiver;

  localparam int FILTER = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic        diode_echo_i = 1'b0;
  logic        result_ready_i = 1'b1;
  logic        result_valid_o;
  logic [15:0] result_width_o;
  logic [1:0]  result_err_o;
  logic        busy_o;
  logic [7:0]  overrun_cnt_o;

  diods_echo_receiver dut (
    .clk_200MHz_i   (clk),
    .reset_n        (reset_n),
    .start_i        (start_i),
    .diode_echo_i   (diode_echo_i),
    .result_ready_i (result_ready_i),
    .result_valid_o (result_valid_o),
    .result_width_o (result_width_o),
    .result_err_o   (result_err_o),
    .busy_o         (busy_o),
    .overrun_cnt_o  (overrun_cnt_o)
  );

  always #2.5 clk = ~clk;

  typedef struct {
    int unsigned high;
    logic [15:0] exp_w;
    logic [1:0]  exp_e;
  } vec_t;

  typedef struct {
    logic [15:0] w;
    logic [1:0]  e;
  } res_t;

  res_t sb_q[$];
  res_t mon_exp;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w, input logic [1:0] e);
    res_t r;
    r.w = w;
    r.e = e;
    sb_q.push_back(r);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic shot(input int pre, input int high);
    pulse_start();
    step(pre);
    if (high > 0) begin
      diode_echo_i = 1'b1;
      step(high);
      diode_echo_i = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o && n < 6000) begin
      step(1);
      n++;
    end
    check(name, busy_o, 0);
  endtask

  // Every transfer (valid & ready at the coming edge) must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && result_valid_o && result_ready_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0d/%0d required=none", result_width_o, result_err_o);
      end else begin
        mon_exp = sb_q.pop_front();
        check("result_width", result_width_o, mon_exp.w);
        check("result_err", result_err_o, mon_exp.e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   n;

    vecs[0] = '{100, 16'd100, 2'b00};
    vecs[1] = '{6,   16'd6,   2'b01};
    vecs[2] = '{7,   16'd7,   2'b01};
    vecs[3] = '{8,   16'd8,   2'b00};
    vecs[4] = '{3,   16'd0,   2'b11};
    vecs[5] = '{20,  16'd20,  2'b00};

    step(3);
    check("rst_valid", result_valid_o, 0);
    check("rst_width", result_width_o, 0);
    check("rst_err", result_err_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_overrun", overrun_cnt_o, 0);
    reset_n = 1'b1;
    step(2);

    for (int i = 0; i < 6; i++) begin
      push(vecs[i].exp_w, vecs[i].exp_e);
      shot(50, vecs[i].high);
      wait_idle("vec_idle");
    end

    // Clean echo: exact result latency after input fall, one-cycle valid with ready high.
    pulse_start();
    check("busy_after_start", busy_o, 1);
    step(49);
    diode_echo_i = 1'b1;
    push(16'd100, 2'b00);
    step(100);
    diode_echo_i = 1'b0;
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      n++;
      #1;
      if (result_valid_o) break;
    end
    check("valid_latency", n, FILTER + 3);
    step(1);
    check("valid_one_cycle", result_valid_o, 0);

    // Low glitch of FILTER-1 cycles inside a 200-cycle high.
    push(16'd200, 2'b00);
    pulse_start();
    step(50);
    diode_echo_i = 1'b1;
    step(100);
    diode_echo_i = 1'b0;
    step(3);
    diode_echo_i = 1'b1;
    step(97);
    diode_echo_i = 1'b0;
    wait_idle("glitch_idle");

    // Stuck high: too-long result, then hold busy until the line drops.
    push(16'd4000, 2'b10);
    pulse_start();
    step(50);
    diode_echo_i = 1'b1;
    n = 0;
    while (!result_valid_o && n < 5000) begin
      step(1);
      n++;
    end
    check("long_valid", result_valid_o, 1);
    step(20);
    check("long_busy_wait_low", busy_o, 1);
    diode_echo_i = 1'b0;
    wait_idle("long_idle");
    push(16'd30, 2'b00);
    shot(10, 30);
    wait_idle("after_long_idle");

    // Arm while echo already high; start during HIGH ignored.
    diode_echo_i = 1'b1;
    step(20);
    pulse_start();
    step(10);
    diode_echo_i = 1'b0;
    step(10);
    diode_echo_i = 1'b1;
    push(16'd20, 2'b00);
    step(8);
    pulse_start();
    step(11);
    diode_echo_i = 1'b0;
    wait_idle("armhigh_idle");
    step(5);
    check("start_in_high_ignored", busy_o, 0);

    // Backpressure: hold, drop, then replace on the load edge.
    result_ready_i = 1'b0;
    push(16'd10, 2'b00);
    shot(5, 10);
    wait_idle("bp_a_idle");
    check("bp_held_valid", result_valid_o, 1);
    shot(5, 12);
    wait_idle("bp_b_idle");
    check("bp_held_width", result_width_o, 10);
    check("bp_held_err", result_err_o, 0);
    check("bp_overrun1", overrun_cnt_o, 1);
    push(16'd14, 2'b00);
    pulse_start();
    step(5);
    diode_echo_i = 1'b1;
    step(14);
    diode_echo_i = 1'b0;
    step(FILTER + 2);
    result_ready_i = 1'b1;
    step(1);
    check("bp_replace_width", result_width_o, 14);
    check("bp_overrun_unchanged", overrun_cnt_o, 1);
    step(1);
    check("bp_drained", result_valid_o, 0);

    // Saturating overrun count.
    result_ready_i = 1'b0;
    push(16'd10, 2'b00);
    shot(3, 10);
    wait_idle("sat_first_idle");
    for (int k = 0; k < 300; k++) begin
      shot(3, 10);
      wait_idle("sat_idle");
    end
    check("overrun_saturated", overrun_cnt_o, 255);
    result_ready_i = 1'b1;
    step(2);
    check("sat_drained", result_valid_o, 0);

    // Asynchronous reset in the middle of a pulse.
    pulse_start();
    step(10);
    diode_echo_i = 1'b1;
    step(30);
    check("pre_reset_busy", busy_o, 1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_valid", result_valid_o, 0);
    check("arst_width", result_width_o, 0);
    check("arst_overrun", overrun_cnt_o, 0);
    step(2);
    reset_n = 1'b1;
    step(10);
    diode_echo_i = 1'b0;
    step(100);
    check("post_reset_idle", busy_o, 0);
    check("post_reset_no_result", result_valid_o, 0);
    push(16'd40, 2'b00);
    shot(20, 40);
    wait_idle("final_idle");
    step(3);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
